// File: rtl/otp_pkg.sv
// rtl/otp_pkg.sv - shared modes, status codes and sequencer states
package otp_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_READ = 2'b01;
  localparam logic [1:0] MODE_PROG = 2'b10;

  typedef enum logic [1:0] {
    ST_OK          = 2'b00,
    ST_VERIFY_FAIL = 2'b01,
    ST_ILLEGAL     = 2'b10,
    ST_TIMEOUT     = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CHECK,
    S_PROG,
    S_GAP,
    S_VERIFY,
    S_RESP
  } state_e;

  // Controller mode presented while the sequencer sits in a given state
  function automatic logic [1:0] state_mode(input state_e s);
    case (s)
      S_RD, S_VERIFY: return MODE_READ;
      S_PROG:         return MODE_PROG;
      default:        return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/otp_prog_sequencer_if.sv
// rtl/otp_prog_sequencer_if.sv - host request/response and controller signal bundle
interface otp_prog_sequencer_if #(
  parameter int A          = 2,
  parameter int ADDR_WIDTH = 1
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op;
  logic [ADDR_WIDTH-1:0] req_column;
  logic [A-1:0]          req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [A-1:0]          rsp_data;
  logic [1:0]            rsp_status;
  logic [1:0]            ctl_mode;
  logic [ADDR_WIDTH-1:0] ctl_column;
  logic [A-1:0]          ctl_data_in;
  logic                  ctl_read_active;
  logic [A-1:0]          ctl_data_out;

  // Host plus array-controller side
  modport master (
    output req_valid, req_op, req_column, req_data, rsp_ready,
           ctl_read_active, ctl_data_out,
    input  req_ready, rsp_valid, rsp_data, rsp_status,
           ctl_mode, ctl_column, ctl_data_in
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_column, req_data, rsp_ready,
           ctl_read_active, ctl_data_out,
    output req_ready, rsp_valid, rsp_data, rsp_status,
           ctl_mode, ctl_column, ctl_data_in
  );

endinterface

// File: rtl/otp_read_waiter.sv
// rtl/otp_read_waiter.sv - READ handshake with bounded wait, shared by RD and VERIFY
module otp_read_waiter #(
  parameter int A          = 2,
  parameter int RD_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_read_active,
  input  logic [A-1:0] i_data_out,
  output logic         o_done,
  output logic         o_timeout,
  output logic [A-1:0] o_data
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  logic [TW-1:0] r_wait_cnt;

  // Count read cycles spent waiting; restarts from zero on every new read phase
  always_ff @(posedge clk) begin
    if (!reset || !i_en || i_read_active) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign o_done    = i_en & i_read_active;
  assign o_timeout = i_en & ~i_read_active & (r_wait_cnt == TW'(RD_TIMEOUT - 1));
  assign o_data    = i_data_out;

endmodule

// File: rtl/otp_prog_sequencer.sv
// rtl/otp_prog_sequencer.sv - read / check / pulse / verify sequencer for the OTP controller
module otp_prog_sequencer
  import otp_pkg::*;
#(
  parameter int A            = 2,
  parameter int B            = 2,
  parameter int PULSE_CYCLES = 8,
  parameter int MAX_RETRY    = 3,
  parameter int RD_TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  otp_prog_sequencer_if.slave  bus
);

  localparam int ADDR_WIDTH = (B > 1) ? $clog2(B) : 1;
  localparam int RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int PW         = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  state_e                r_state;
  state_e                w_next;
  status_e               r_rsp_status;
  status_e               w_status;
  logic                  r_op;
  logic [A-1:0]          r_req_data;
  logic [A-1:0]          r_cap;
  logic [A-1:0]          r_rsp_data;
  logic [A-1:0]          r_ctl_data_in;
  logic [ADDR_WIDTH-1:0] r_ctl_column;
  logic [1:0]            r_ctl_mode;
  logic [RW-1:0]         r_retry;
  logic [PW-1:0]         r_pulse_cnt;

  logic                  w_accept;
  logic                  w_load_rsp;
  logic                  w_retry_inc;
  logic                  w_rd_en;
  logic                  w_rd_done;
  logic                  w_rd_timeout;
  logic [A-1:0]          w_rd_data;
  logic [A-1:0]          w_cur;
  logic [A-1:0]          w_pgm_bits;
  logic                  w_illegal;
  logic                  w_last_pulse;

  otp_read_waiter #(
    .A          (A),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) u_read_waiter (
    .clk           (clk),
    .reset         (reset),
    .i_en          (w_rd_en),
    .i_read_active (bus.ctl_read_active),
    .i_data_out    (bus.ctl_data_out),
    .o_done        (w_rd_done),
    .o_timeout     (w_rd_timeout),
    .o_data        (w_rd_data)
  );

  // The word under judgement is the live read data in its capture cycle, else the last capture
  assign w_rd_en      = (r_state == S_RD) || (r_state == S_VERIFY);
  assign w_cur        = w_rd_done ? w_rd_data : r_cap;
  assign w_pgm_bits   = r_req_data & ~w_cur;
  assign w_illegal    = |(w_cur & ~r_req_data);
  assign w_last_pulse = (r_pulse_cnt == PW'(PULSE_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decisions and response status selection
  always_comb begin
    w_next      = r_state;
    w_status    = ST_OK;
    w_load_rsp  = 1'b0;
    w_retry_inc = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          w_next   = S_RD;
        end
      end
      S_RD: begin
        if (w_rd_done) begin
          if (!r_op) begin
            w_next     = S_RESP;
            w_load_rsp = 1'b1;
          end else begin
            w_next = S_CHECK;
          end
        end else if (w_rd_timeout) begin
          w_next     = S_RESP;
          w_load_rsp = 1'b1;
          w_status   = ST_TIMEOUT;
        end
      end
      S_CHECK: begin
        if (w_illegal) begin
          w_next     = S_RESP;
          w_load_rsp = 1'b1;
          w_status   = ST_ILLEGAL;
        end else if (w_pgm_bits == '0) begin
          w_next     = S_RESP;
          w_load_rsp = 1'b1;
        end else begin
          w_next = S_PROG;
        end
      end
      S_PROG: begin
        if (w_last_pulse) begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        w_next = S_VERIFY;
      end
      S_VERIFY: begin
        if (w_rd_done) begin
          if (w_cur == r_req_data) begin
            w_next     = S_RESP;
            w_load_rsp = 1'b1;
          end else if (w_illegal) begin
            w_next     = S_RESP;
            w_load_rsp = 1'b1;
            w_status   = ST_ILLEGAL;
          end else if (r_retry < RW'(MAX_RETRY)) begin
            w_retry_inc = 1'b1;
            w_next      = S_PROG;
          end else begin
            w_next     = S_RESP;
            w_load_rsp = 1'b1;
            w_status   = ST_VERIFY_FAIL;
          end
        end else if (w_rd_timeout) begin
          w_next     = S_RESP;
          w_load_rsp = 1'b1;
          w_status   = ST_TIMEOUT;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request latches, captured read data, retry/pulse counters and registered controller drive
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op          <= 1'b0;
      r_req_data    <= '0;
      r_cap         <= '0;
      r_rsp_data    <= '0;
      r_rsp_status  <= ST_OK;
      r_ctl_data_in <= '0;
      r_ctl_column  <= '0;
      r_ctl_mode    <= MODE_IDLE;
      r_retry       <= '0;
      r_pulse_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_op         <= bus.req_op;
        r_ctl_column <= bus.req_column;
        r_req_data   <= bus.req_data;
        r_retry      <= '0;
      end
      if (w_rd_done) begin
        r_cap <= w_rd_data;
      end
      if (w_retry_inc) begin
        r_retry <= r_retry + 1'b1;
      end
      if (w_load_rsp) begin
        r_rsp_data   <= w_cur;
        r_rsp_status <= w_status;
      end
      r_ctl_mode <= state_mode(w_next);
      // Pulse bits are fixed on PROG entry and held for the whole window
      if (w_next == S_PROG && r_state != S_PROG) begin
        r_ctl_data_in <= w_pgm_bits;
      end else if (w_next != S_PROG) begin
        r_ctl_data_in <= '0;
      end
      r_pulse_cnt <= (r_state == S_PROG && w_next == S_PROG) ? r_pulse_cnt + 1'b1 : '0;
    end
  end

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.rsp_valid   = (r_state == S_RESP);
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_status  = r_rsp_status;
  assign bus.ctl_mode    = r_ctl_mode;
  assign bus.ctl_column  = r_ctl_column;
  assign bus.ctl_data_in = r_ctl_data_in;

endmodule

// File: tb/tb_otp_prog_sequencer.sv
// tb/tb_otp_prog_sequencer.sv - directed-vector bench for otp_prog_sequencer
module tb_otp_prog_sequencer;
  import otp_pkg::*;

  localparam int A  = 2;
  localparam int B  = 2;
  localparam int AW = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  otp_prog_sequencer_if #(.A(A), .ADDR_WIDTH(AW)) bus ();

  otp_prog_sequencer #(
    .A(A), .B(B), .PULSE_CYCLES(8), .MAX_RETRY(3), .RD_TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // controller model settings (written by the main flow only)
  logic       mon_clr;
  int         rd_delay;
  int         rd_n;
  logic [1:0] rd_vals [3];

  // monitor results (written by the monitor only)
  int         rd_cycles, rd_phase, rd_idx, prog_cycles, n_pulses, abut, unstable, col_seen;
  int         pulse_len [8];
  logic [1:0] pulse_dat [8];
  logic [1:0] prev_mode;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // controller model and mode monitor, acting on the falling edge
  always @(negedge clk) begin
    logic [1:0] m;
    m = bus.ctl_mode;
    if (mon_clr) begin
      rd_cycles = 0; rd_phase = 0; rd_idx = 0; prog_cycles = 0;
      n_pulses = 0; abut = 0; unstable = 0; col_seen = -1;
      prev_mode = MODE_IDLE;
      bus.ctl_read_active = 1'b0;
      bus.ctl_data_out = 2'b11;
    end else begin
      if (prev_mode == MODE_PROG && m == MODE_READ) abut++;
      bus.ctl_read_active = 1'b0;
      bus.ctl_data_out = 2'b11;
      if (m == MODE_READ) begin
        if (prev_mode != MODE_READ) rd_phase = 0;
        rd_phase++;
        rd_cycles++;
        col_seen = int'(bus.ctl_column);
        if (rd_delay != 0 && rd_phase == rd_delay) begin
          bus.ctl_read_active = 1'b1;
          bus.ctl_data_out = rd_vals[(rd_idx < rd_n) ? rd_idx : rd_n - 1];
          rd_idx++;
        end
      end
      if (m == MODE_PROG) begin
        prog_cycles++;
        if (prev_mode != MODE_PROG && n_pulses < 8) begin
          pulse_len[n_pulses] = 0;
          pulse_dat[n_pulses] = bus.ctl_data_in;
          n_pulses++;
        end
        if (n_pulses > 0) begin
          pulse_len[n_pulses-1]++;
          if (bus.ctl_data_in != pulse_dat[n_pulses-1]) unstable++;
        end
      end
      prev_mode = m;
    end
  end

  task automatic setup(input int delay, input logic [1:0] v0, input logic [1:0] v1,
                       input logic [1:0] v2, input int n);
    rd_delay = delay;
    rd_vals[0] = v0; rd_vals[1] = v1; rd_vals[2] = v2;
    rd_n = n;
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic send(input logic op, input logic col, input logic [1:0] data);
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) break;
      @(posedge clk); #1;
    end
    check_val("req_ready_before_send", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_column = col; bus.req_data = data;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic run_op(input logic op, input logic col, input logic [1:0] data, output int lat);
    logic ok;
    send(op, col, data);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.rsp_valid) begin ok = 1'b1; break; end
    end
    check_val("rsp_arrived", ok, 1);
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check_val("post_rsp_req_ready", bus.req_ready, 1);
    check_val("post_rsp_rsp_valid", bus.rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int  lat;
    logic seen;
    reset = 1'b0; mon_clr = 1'b1;
    rd_delay = 1; rd_n = 1;
    rd_vals[0] = 2'b00; rd_vals[1] = 2'b00; rd_vals[2] = 2'b00;
    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_column = 1'b0; bus.req_data = 2'b00;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req_ready", bus.req_ready, 1);
    check_val("rst_rsp_valid", bus.rsp_valid, 0);
    check_val("rst_rsp_data", bus.rsp_data, 0);
    check_val("rst_rsp_status", bus.rsp_status, 0);
    check_val("rst_ctl_mode", bus.ctl_mode, 0);
    check_val("rst_ctl_column", bus.ctl_column, 0);
    check_val("rst_ctl_data_in", bus.ctl_data_in, 0);
    reset = 1'b1;

    // read col 1, data after 3 read cycles, response held under backpressure
    setup(3, 2'b10, 2'b00, 2'b00, 1);
    run_op(1'b0, 1'b1, 2'b00, lat);
    check_val("rd_lat", lat, 3);
    check_val("rd_status", bus.rsp_status, 0);
    check_val("rd_data", bus.rsp_data, 2'b10);
    check_val("rd_read_cycles", rd_cycles, 3);
    check_val("rd_prog_cycles", prog_cycles, 0);
    check_val("rd_column", col_seen, 1);
    repeat (3) @(posedge clk);
    #1;
    check_val("rd_hold_valid", bus.rsp_valid, 1);
    check_val("rd_hold_data", bus.rsp_data, 2'b10);
    check_val("rd_hold_ready", bus.req_ready, 0);
    finish_rsp();

    // program 11 into blank word, verify clean
    setup(1, 2'b00, 2'b11, 2'b11, 2);
    run_op(1'b1, 1'b0, 2'b11, lat);
    check_val("p1_lat", lat, 12);
    check_val("p1_status", bus.rsp_status, 0);
    check_val("p1_data", bus.rsp_data, 2'b11);
    check_val("p1_pulses", n_pulses, 1);
    check_val("p1_pulse_len", pulse_len[0], 8);
    check_val("p1_pulse_bits", pulse_dat[0], 2'b11);
    check_val("p1_abut", abut, 0);
    check_val("p1_unstable", unstable, 0);
    check_val("p1_read_cycles", rd_cycles, 2);
    finish_rsp();

    // program 01 over 10: would clear a bit
    setup(1, 2'b10, 2'b10, 2'b10, 1);
    run_op(1'b1, 1'b1, 2'b01, lat);
    check_val("ill_lat", lat, 2);
    check_val("ill_status", bus.rsp_status, 2'b10);
    check_val("ill_data", bus.rsp_data, 2'b10);
    check_val("ill_prog_cycles", prog_cycles, 0);
    finish_rsp();

    // program 11 over 01, verify stuck at 01: all retries used
    setup(1, 2'b01, 2'b01, 2'b01, 2);
    run_op(1'b1, 1'b0, 2'b11, lat);
    check_val("vf_status", bus.rsp_status, 2'b01);
    check_val("vf_data", bus.rsp_data, 2'b01);
    check_val("vf_pulses", n_pulses, 4);
    check_val("vf_prog_cycles", prog_cycles, 32);
    check_val("vf_abut", abut, 0);
    check_val("vf_unstable", unstable, 0);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("vf_pulse_bits_%0d", i), pulse_dat[i], 2'b10);
      check_val($sformatf("vf_pulse_len_%0d", i), pulse_len[i], 8);
    end
    finish_rsp();

    // program 11 over 00, first verify partial, second clean
    setup(1, 2'b00, 2'b01, 2'b11, 3);
    run_op(1'b1, 1'b0, 2'b11, lat);
    check_val("rt_status", bus.rsp_status, 0);
    check_val("rt_data", bus.rsp_data, 2'b11);
    check_val("rt_pulses", n_pulses, 2);
    check_val("rt_pulse0_bits", pulse_dat[0], 2'b11);
    check_val("rt_pulse1_bits", pulse_dat[1], 2'b10);
    check_val("rt_abut", abut, 0);
    finish_rsp();

    // program 01 over 01: nothing to do
    setup(1, 2'b01, 2'b01, 2'b01, 1);
    run_op(1'b1, 1'b0, 2'b01, lat);
    check_val("np_status", bus.rsp_status, 0);
    check_val("np_data", bus.rsp_data, 2'b01);
    check_val("np_prog_cycles", prog_cycles, 0);
    finish_rsp();

    // read with no read_active: timeout
    setup(0, 2'b00, 2'b00, 2'b00, 1);
    run_op(1'b0, 1'b0, 2'b00, lat);
    check_val("to_lat", lat, 16);
    check_val("to_status", bus.rsp_status, 2'b11);
    check_val("to_read_cycles", rd_cycles, 16);
    finish_rsp();

    // reset in the middle of a pulse
    setup(1, 2'b00, 2'b11, 2'b11, 2);
    send(1'b1, 1'b1, 2'b11);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.ctl_mode == MODE_PROG) begin seen = 1'b1; break; end
    end
    check_val("mr_prog_seen", seen, 1);
    check_val("mr_prog_column", bus.ctl_column, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_val("mr_ctl_mode", bus.ctl_mode, 0);
    check_val("mr_req_ready", bus.req_ready, 1);
    check_val("mr_rsp_valid", bus.rsp_valid, 0);
    check_val("mr_ctl_data_in", bus.ctl_data_in, 0);
    reset = 1'b1;

    // sequencer usable again after the abort
    setup(2, 2'b01, 2'b01, 2'b01, 1);
    run_op(1'b0, 1'b0, 2'b00, lat);
    check_val("rc_lat", lat, 2);
    check_val("rc_status", bus.rsp_status, 0);
    check_val("rc_data", bus.rsp_data, 2'b01);
    finish_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/otp_prog_sequencer.md
Name: otp_prog_sequencer

Overview:
- Request-level sequencer in front of the OTP array controller FSM. It converts single read/program requests into controller mode/column/data sequences.
- Program requests run as read-check, then program pulse, then read-verify, with bounded retries; the OTP rule that bits only go 0->1 is enforced.
- Sits between the host/register interface and the OTP controller; the controller never sees an illegal or redundant program.

Parameters:
- A, 2, data word width (bits per column word)
- B, 2, number of columns
- ADDR_WIDTH, max(1,$clog2(B)), column index width (derived localparam)
- PULSE_CYCLES, 8, cycles ctl_mode is held at PROG per pulse (>=1)
- MAX_RETRY, 3, extra program pulses after the first failed verify
- RD_TIMEOUT, 16, max cycles waiting for ctl_read_active

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer accepts request (high only in IDLE)
- req_op  in  1  0=read, 1=program
- req_column  in  ADDR_WIDTH  target column
- req_data  in  A  target word (program only)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  A  last word read from array
- rsp_status  out  2  00 OK, 01 VERIFY_FAIL, 10 ILLEGAL (1->0 requested), 11 TIMEOUT
- ctl_mode  out  2  controller mode: 00 IDLE, 01 READ, 10 PROG
- ctl_column  out  ADDR_WIDTH  controller column
- ctl_data_in  out  A  bits to program (1 = program this bit)
- ctl_read_active  in  1  controller read data valid this cycle
- ctl_data_out  in  A  controller read data

Behaviour:
- Reset (reset==0 at posedge): state IDLE; req_ready=1, rsp_valid=0, rsp_data=0, rsp_status=00, ctl_mode=00, ctl_column=0, ctl_data_in=0, retry count=0. Reset mid-operation aborts at once; ctl_mode is IDLE the cycle after.
- States: IDLE, RD, CHECK, PROG, GAP, VERIFY, RESP.
- IDLE: req_valid&&req_ready latches op/column/data. Next state RD; ctl_mode=READ from the next cycle. No other state accepts a request.
- RD / VERIFY:
  - ctl_mode=READ and ctl_column=latched column are held until ctl_read_active=1; ctl_data_out is captured that cycle.
  - A wait counter starts at 0 on entry. If RD_TIMEOUT cycles pass without ctl_read_active, go to RESP with status 11.
  - RD with read op: go to RESP with status 00 and rsp_data = captured word.
  - RD with program op: go to CHECK.
- CHECK (1 cycle, ctl_mode IDLE):
  - Computes cur = captured word.
  - If cur & ~req_data != 0: RESP, status 10, no pulse issued.
  - Else if req_data & ~cur == 0: RESP, status 00 (already programmed).
  - Else: ctl_data_in = req_data & ~cur; go to PROG.
- PROG: ctl_mode=PROG for exactly PULSE_CYCLES cycles; ctl_column and ctl_data_in are stable throughout. Then GAP.
- GAP: 1 cycle with ctl_mode=IDLE, then VERIFY. A pulse never directly abuts a read.
- After VERIFY:
  - If captured == req_data: RESP 00.
  - Else if a bit is 1 in the array but 0 in the request: RESP 10.
  - Else if retry < MAX_RETRY: retry++, ctl_data_in = req_data & ~captured, go to PROG.
  - Else: RESP 01.
  - Total pulses are at most 1+MAX_RETRY.
- RESP: rsp_valid=1; rsp_data/rsp_status stable until rsp_valid&&rsp_ready. Next state is IDLE, with rsp_valid=0 and req_ready=1 the next cycle. ctl_mode=IDLE throughout RESP.
- ctl_mode is registered. ctl_mode never goes from PROG to READ without an intervening IDLE cycle. No state other than PROG ever drives ctl_mode=PROG.
- Latency, program, no retry, read_active on first READ cycle: accept -> RD(1) -> CHECK(1) -> PROG(PULSE_CYCLES) -> GAP(1) -> VERIFY(1) -> rsp_valid.
- Width rules: all comparisons are bitwise over A bits. Retry counter width is $clog2(MAX_RETRY+1), saturating. Timeout counter width is $clog2(RD_TIMEOUT+1).

Decomposition:
- Package otp_pkg:
  - mode localparams MODE_IDLE/MODE_READ/MODE_PROG
  - status enum OK/VERIFY_FAIL/ILLEGAL/TIMEOUT
  - state enum
- Optional sub-module otp_read_waiter: the READ handshake with timeout, shared by RD and VERIFY. Returns done, timeout and data.

Test Plan (A=2, B=2, PULSE_CYCLES=8, MAX_RETRY=3):
- Read col 1; model returns 2'b10 after 3 cycles -> rsp_status 00, rsp_data 10; ctl_mode READ for 3 cycles, never PROG.
- Program col 0 data 11, array 00, verify returns 11 -> one PROG window of exactly 8 cycles with ctl_data_in 11; GAP IDLE cycle; status 00.
- Program col 1 data 01, array 10 -> status 10, zero PROG cycles, rsp_data 10.
- Program col 0 data 11, array 01, verify always returns 01 -> 4 pulses with ctl_data_in 10; status 01.
- Program 11, array 00, first verify 01 -> second pulse ctl_data_in 10, verify 11 -> status 00.
- Read with ctl_read_active held low -> status 11 after 16 wait cycles. Then reset low mid-PROG -> ctl_mode 00 the next cycle, req_ready 1, rsp_valid 0.
